// File: rtl/djs130_tti_fifo.sv
// DJS130 teletype-input (TTI) controller with a receive FIFO.
// Received characters queue in a DEPTH-entry FIFO; each programmed-I/O Start
// moves one character into the data register DB for the CPU to read via DIA.
// Optional build macro: DJS130_TTI_STATUS_EN -- when defined, DIA bits 15:8
// carry {overrun, FIFO occupancy saturated to 7 bits}; otherwise they are 0.
module djs130_tti_fifo #(
    parameter logic [5:0]  DEV_CODE = 6'o10,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MASK_BIT = 14
) (
    input  logic                     i_clk,
    input  logic                     i_ZZ0,
    input  logic                     i_wr,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [5:0]               i_dev_addr,
    input  logic                     i_kzs,
    input  logic                     i_kzc,
    input  logic                     i_dia,
    input  logic                     i_msko,
    input  logic [15:0]              i_msk_data,
    output logic [15:0]              o_dev_SC,
    output logic                     o_dev_ZDQQ,
    output logic [5:0]               o_dev_DMS,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_full,
    output logic                     o_overrun,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Flag register encoded as {Busy, Done}
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b10,
        ST_READY = 2'b01
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   db;
    logic                overrun;
    logic                mask;
    logic                zdqq;

    logic                sel;
    logic                start;
    logic                clear;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic [7:0]          db8;
    logic [15:0]         rd_word;

    // Only MASK_BIT of the mask word matters to this device
    logic                unused_msk_bits;
    assign unused_msk_bits = ^i_msk_data;

    // Address qualification and FIFO handshake decode
    always_comb begin
        sel        = (i_dev_addr == DEV_CODE);
        start      = sel & i_kzs;
        clear      = sel & i_kzc;
        fifo_full  = (count == CNT_W'(DEPTH));
        fifo_empty = (count == '0);
        // Clear beats the pending pop so the FIFO is left untouched
        pop        = (state == ST_WAIT) && !fifo_empty && !clear;
        // A full FIFO still accepts a write when the head leaves in the same cycle
        push       = i_wr && (!fifo_full || pop);
        drop       = i_wr && fifo_full && !pop;
    end

    // FIFO storage (no reset needed: contents are only read behind count)
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[tail] <= i_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_ZZ0) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Busy/Done state machine and the data register loaded on each pop
    always_ff @(posedge i_clk) begin
        if (i_ZZ0) begin
            state <= ST_IDLE;
            db    <= '0;
        end else begin
            if (pop) begin
                db <= mem[head];
            end
            if (clear) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  if (start) state <= ST_WAIT;
                    ST_WAIT:  if (!fifo_empty) state <= ST_READY;
                    ST_READY: if (start) state <= ST_WAIT;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    // Overrun, interrupt mask and the registered interrupt request
    always_ff @(posedge i_clk) begin
        if (i_ZZ0) begin
            overrun <= 1'b0;
            mask    <= 1'b0;
            zdqq    <= 1'b0;
        end else begin
            // A character lost in the same cycle as Clear is still reported
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear) begin
                overrun <= 1'b0;
            end
            if (i_msko) begin
                mask <= i_msk_data[MASK_BIT];
            end
            zdqq <= state[0] & ~mask;
        end
    end

    // DIA read word, driven onto the bus only while selected
    always_comb begin
        db8 = 8'(db);
`ifdef DJS130_TTI_STATUS_EN
        rd_word = {overrun,
                   (32'(count) > 32'd127) ? 7'h7F : 7'(count),
                   db8};
`else
        rd_word = {8'h00, db8};
`endif
        o_dev_SC = (sel && i_dia) ? rd_word : '0;
    end

    assign o_dev_ZDQQ = zdqq;
    assign o_dev_DMS  = DEV_CODE;
    assign o_busy     = state[1];
    assign o_done     = state[0];
    assign o_full     = fifo_full;
    assign o_overrun  = overrun;
    assign o_count    = count;

endmodule

// File: tb/tb_djs130_tti_fifo.sv
// Directed bench for djs130_tti_fifo (DEV_CODE=6'o10, DATA_W=8, DEPTH=16).
module tb_djs130_tti_fifo;

    logic        clk = 1'b0;
    logic        zz0 = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  data = '0;
    logic [5:0]  dev_addr = 6'o10;
    logic        kzs = 1'b0;
    logic        kzc = 1'b0;
    logic        dia = 1'b0;
    logic        msko = 1'b0;
    logic [15:0] msk_data = '0;
    logic [15:0] sc;
    logic        zdqq;
    logic [5:0]  dms;
    logic        busy;
    logic        done;
    logic        full;
    logic        overrun;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    djs130_tti_fifo dut (
        .i_clk      (clk),
        .i_ZZ0      (zz0),
        .i_wr       (wr),
        .i_data     (data),
        .i_dev_addr (dev_addr),
        .i_kzs      (kzs),
        .i_kzc      (kzc),
        .i_dia      (dia),
        .i_msko     (msko),
        .i_msk_data (msk_data),
        .o_dev_SC   (sc),
        .o_dev_ZDQQ (zdqq),
        .o_dev_DMS  (dms),
        .o_busy     (busy),
        .o_done     (done),
        .o_full     (full),
        .o_overrun  (overrun),
        .o_count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        zz0 = 1'b1; wr = 1'b1; data = 8'hFF; kzs = 1'b1; msko = 1'b1; msk_data = 16'hFFFF;
        step();
        zz0 = 1'b0; wr = 1'b0; kzs = 1'b0; msko = 1'b0; msk_data = '0;
        dia = 1'b1; #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {busy, done}); end
        checks++; if (zdqq !== 1'b0) begin errors++; $display("FAIL reset_zdqq: got %b want 0", zdqq); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (sc !== 16'h0000) begin errors++; $display("FAIL reset_sc: got %h want 0000", sc); end
        checks++; if (dms !== 6'o10) begin errors++; $display("FAIL reset_dms: got %o want 10", dms); end
        dia = 1'b0;
    endtask

    task automatic test_single_char();
        kzs = 1'b1; step(); kzs = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL single_wait: got %b want 10", {busy, done}); end
        wr = 1'b1; data = 8'h41; step(); wr = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", done); end
        step();
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", {busy, done}); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (zdqq !== 1'b0) begin errors++; $display("FAIL single_zdqq_early: got %b want 0", zdqq); end
        step();
        checks++; if (zdqq !== 1'b1) begin errors++; $display("FAIL single_zdqq: got %b want 1", zdqq); end
        dia = 1'b1; #1;
        checks++; if (sc !== 16'h0041) begin errors++; $display("FAIL single_dia: got %h want 0041", sc); end
        dia = 1'b0;
    endtask

    task automatic test_multi();
        logic [15:0] exp_sc [3];
        exp_sc[0] = 16'h0031; exp_sc[1] = 16'h0032; exp_sc[2] = 16'h0033;
        kzc = 1'b1; step(); kzc = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL clear_flags: got %b want 00", {busy, done}); end
        checks++; if (zdqq !== 1'b1) begin errors++; $display("FAIL clear_zdqq_lag: got %b want 1", zdqq); end
        step();
        checks++; if (zdqq !== 1'b0) begin errors++; $display("FAIL clear_zdqq_fall: got %b want 0", zdqq); end
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; data = 8'h31 + 8'(i); step();
        end
        wr = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL multi_count3: got %0d want 3", count); end
        for (int k = 0; k < 3; k++) begin
            kzs = 1'b1; step(); kzs = 1'b0;
            checks++; if (count !== 5'(3 - k)) begin errors++; $display("FAIL multi_pre_pop%0d: got %0d want %0d", k, count, 3 - k); end
            step();
            checks++; if (count !== 5'(2 - k)) begin errors++; $display("FAIL multi_post_pop%0d: got %0d want %0d", k, count, 2 - k); end
            dia = 1'b1; #1;
            checks++; if (sc !== exp_sc[k]) begin errors++; $display("FAIL multi_dia%0d: got %h want %h", k, sc, exp_sc[k]); end
            dia = 1'b0;
        end
    endtask

    task automatic test_overrun();
        kzc = 1'b1; step(); kzc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data = 8'h40 + 8'(i); step();
        end
        wr = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_filled: got count=%0d full=%b ovr=%b want 16 1 0", count, full, overrun); end
        wr = 1'b1; data = 8'hEE; step(); wr = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_drop: got count=%0d full=%b ovr=%b want 16 1 1", count, full, overrun); end
        kzc = 1'b1; step(); kzc = 1'b0;
        checks++; if (overrun !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL ovr_clear: got ovr=%b count=%0d want 0 16", overrun, count); end
        kzs = 1'b1; step(); kzs = 1'b0;
        wr = 1'b1; data = 8'hA5; step(); wr = 1'b0;
        checks++; if (count !== 5'd16 || overrun !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ovr_pushpop: got count=%0d ovr=%b done=%b want 16 0 1", count, overrun, done); end
        dia = 1'b1; #1;
        checks++; if (sc !== 16'h0040) begin errors++; $display("FAIL ovr_head: got %h want 0040", sc); end
        dia = 1'b0;
    endtask

    task automatic test_mask();
        step();
        checks++; if (zdqq !== 1'b1) begin errors++; $display("FAIL mask_zdqq_on: got %b want 1", zdqq); end
        msko = 1'b1; msk_data = 16'h4000; step(); msko = 1'b0;
        checks++; if (zdqq !== 1'b1) begin errors++; $display("FAIL mask_lag: got %b want 1", zdqq); end
        step();
        checks++; if (zdqq !== 1'b0) begin errors++; $display("FAIL mask_fall: got %b want 0", zdqq); end
        msko = 1'b1; msk_data = 16'hBFFF; step(); msko = 1'b0;
        checks++; if (zdqq !== 1'b0) begin errors++; $display("FAIL unmask_lag: got %b want 0", zdqq); end
        step();
        checks++; if (zdqq !== 1'b1) begin errors++; $display("FAIL unmask_rise: got %b want 1", zdqq); end
    endtask

    task automatic test_start_clear();
        kzs = 1'b1; kzc = 1'b1; step(); kzs = 1'b0; kzc = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || count !== 5'd16) begin errors++; $display("FAIL sc_both: got flags=%b count=%0d want 00 16", {busy, done}, count); end
        step();
        checks++; if (zdqq !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL sc_idle: got zdqq=%b count=%0d want 0 16", zdqq, count); end
        dev_addr = 6'o11; kzs = 1'b1; dia = 1'b1; #1;
        checks++; if (sc !== 16'h0000) begin errors++; $display("FAIL unsel_sc: got %h want 0000", sc); end
        step(); kzs = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || count !== 5'd16) begin errors++; $display("FAIL unsel_start: got flags=%b count=%0d want 00 16", {busy, done}, count); end
        dev_addr = 6'o10; kzs = 1'b1; #1;
        checks++; if (sc !== 16'h0040) begin errors++; $display("FAIL dia_start_old: got %h want 0040", sc); end
        step(); kzs = 1'b0;
        checks++; if (busy !== 1'b1 || sc !== 16'h0040) begin errors++; $display("FAIL dia_wait: got busy=%b sc=%h want 1 0040", busy, sc); end
        step();
        checks++; if (sc !== 16'h0041 || count !== 5'd15) begin errors++; $display("FAIL dia_next: got sc=%h count=%0d want 0041 15", sc, count); end
        dia = 1'b0;
    endtask

    task automatic test_status();
        logic [15:0] exp;
        zz0 = 1'b1; step(); zz0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data = (i == 12) ? 8'h5A : 8'h10 + 8'(i); step();
        end
        data = 8'h77; step(); wr = 1'b0;
        for (int k = 0; k < 13; k++) begin
            kzs = 1'b1; step(); kzs = 1'b0; step();
        end
        checks++; if (count !== 5'd3 || overrun !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL status_state: got count=%0d ovr=%b done=%b want 3 1 1", count, overrun, done); end
`ifdef DJS130_TTI_STATUS_EN
        exp = 16'h835A;
`else
        exp = 16'h005A;
`endif
        dia = 1'b1; #1;
        checks++; if (sc !== exp) begin errors++; $display("FAIL status_dia: got %h want %h", sc, exp); end
        dia = 1'b0;
    endtask

    task automatic test_reset_wait();
        kzs = 1'b1; step(); kzs = 1'b0;
        checks++; if (busy !== 1'b1 || zdqq !== 1'b1) begin errors++; $display("FAIL rw_pre: got busy=%b zdqq=%b want 1 1", busy, zdqq); end
        zz0 = 1'b1; wr = 1'b1; data = 8'h99; step(); zz0 = 1'b0; wr = 1'b0;
        checks++; if (count !== 5'd0 || {busy, done} !== 2'b00) begin errors++; $display("FAIL rw_state: got count=%0d flags=%b want 0 00", count, {busy, done}); end
        checks++; if (zdqq !== 1'b0 || overrun !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rw_flags: got zdqq=%b ovr=%b full=%b want 0 0 0", zdqq, overrun, full); end
        dia = 1'b1; #1;
        checks++; if (sc !== 16'h0000) begin errors++; $display("FAIL rw_sc: got %h want 0000", sc); end
        dia = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_multi();
        test_overrun();
        test_mask();
        test_start_clear();
        test_status();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/djs130_tti_fifo.md
Name: djs130_tti_fifo

Overview:
- Next-generation DJS130 teletype-input (TTI) device controller.
- Characters from the serial receiver enter a parametrised FIFO.
- Programmed-I/O Start/Clear/DIA operations hand characters one at a time to the CPU through a 16-bit bus.
- Provides Busy/Done flags, a maskable interrupt request, overrun detection and a parametrised device code.

Parameters:
- DEV_CODE, 6'o10: device code. Driven on o_dev_DMS and compared with i_dev_addr.
- DATA_W, 8: character width, legal range 5..8.
- DEPTH, 16: FIFO depth. Power of 2, range 2..64.
- MASK_BIT, 14: bit of the MSKO data word that disables this device's interrupt.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_ZZ0  in  1  reset. Synchronous and active-high.
- i_wr  in  1  receiver write strobe, one cycle per character.
- i_data  in  DATA_W  received character.
- i_dev_addr  in  6  device address from the I/O bus.
- i_kzs  in  1  Start pulse.
- i_kzc  in  1  Clear pulse.
- i_dia  in  1  DIA read enable, level.
- i_msko  in  1  mask-out strobe, not address-qualified.
- i_msk_data  in  16  mask word.
- o_dev_SC  out  16  read data bus.
- o_dev_ZDQQ  out  1  interrupt request.
- o_dev_DMS  out  6  constant DEV_CODE.
- o_busy  out  1  Busy flag.
- o_done  out  1  Done flag.
- o_full  out  1  FIFO full.
- o_overrun  out  1  sticky overrun flag.
- o_count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Address qualification: sel = (i_dev_addr == DEV_CODE). i_kzs, i_kzc and i_dia act only when sel=1.
- Reset (i_ZZ0=1 at a clock edge) clears everything:
  - FIFO is emptied.
  - Busy, Done, overrun, mask and ZDQQ are set to 0.
  - Data register DB is set to 0.
  - Resulting outputs: o_count=0, o_full=0, o_dev_SC=0.
  - Reset overrides all simultaneous inputs.
- FIFO push:
  - i_wr=1 with count<DEPTH writes i_data at the tail.
  - i_wr=1 while full drops the character and sets overrun, unless a pop occurs in the same cycle; then the push is accepted.
  - Pointers wrap modulo DEPTH.
  - o_full = (count==DEPTH).
- Flag state machine (states encoded as {Busy,Done}):
  - IDLE 00: Start -> WAIT 10.
  - WAIT 10: if count≠0 at the start of the cycle, then at the edge pop the head into DB, giving READY 01.
  - READY 01: Start -> WAIT 10. Any further character in the FIFO is not popped until the next Start.
  - Clear in any state -> IDLE 00 and clears overrun. Clear does not flush the FIFO.
  - Start and Clear in the same cycle: Clear wins.
  - Start while already in WAIT: no effect.
- Timing: a character written at cycle t into an empty FIFO in WAIT appears in count at t+1, gives Done=1 after the t+2 edge, and gives ZDQQ=1 after the t+3 edge.
- Push and pop in the same cycle leave count unchanged.
- Read path:
  - o_dev_SC is combinational: {8'b0, zero-extended DB} while sel & i_dia, otherwise 16'h0000.
  - DIA with Start in the same cycle returns the old DB.
- Mask: i_msko loads mask <= i_msk_data[MASK_BIT].
- Interrupt: o_dev_ZDQQ is registered, equal to Done & ~mask, so it lags Done and the mask by one edge.
- Clear drops ZDQQ one edge after Done falls.

Optional Feature:
- Macro: DJS130_TTI_STATUS_EN.
- Defined: DIA data becomes {overrun, occupancy saturated to 7 bits, DB zero-extended to 8}.
- Not defined: bits 15:8 of DIA data are always 0. The overrun flag is still visible on o_overrun.

Test Plan:
- Reset, then sel with Start. Write 8'h41 -> count=1 one edge later; Done=1 two edges later; ZDQQ=1 three edges later; DIA reads 16'h0041; Busy=0.
- Write 8'h31, 8'h32, 8'h33 while IDLE. Start -> DIA reads 16'h0031. Start -> 16'h0032. Start -> 16'h0033. Each pop decrements count; count ends at 0.
- Fill 16 characters with DEPTH=16, then write a 17th -> o_full=1, overrun=1, count=16, character dropped. Clear -> overrun=0, count still 16.
- MSKO with data 16'h4000 while Done=1 -> ZDQQ falls one edge later. MSKO with 16'h0000 -> ZDQQ rises one edge later.
- Start and Clear in the same cycle while READY -> state IDLE, Done=0, no pop. i_dev_addr≠DEV_CODE with Start -> no change; o_dev_SC stays 0 even with i_dia=1.
- With DJS130_TTI_STATUS_EN, after an overrun with 3 characters queued, DB=8'h5A: DIA reads 16'h835A.
- Reset asserted during WAIT with a write in the same cycle -> count=0, flags 00, ZDQQ=0.
